// File: rtl/pipeline_stall_ctrl.sv
// pipeline_stall_ctrl: stall/flush sequencer for the 5-stage RV32 pipeline.
//   Merges the load-use hazard, the multi-cycle mul/div handshake, the data-memory
//   wait and taken-branch events into per-stage write enables and bubble/flush
//   controls. It also counts the cycles in which the PC is held.
// Ports:
//   clk, rst_n           clock (rising edge) and asynchronous active-low reset
//   load_use_hzd         load-use hazard for the instruction in ID
//   md_req_ex, md_done   mul/div instruction in EX / result-valid pulse
//   md_start             one-cycle start pulse to the mul/div unit
//   dmem_req, dmem_ready MEM access in progress / access completes this cycle
//   br_taken_ex          taken branch/jump resolved in EX
//   *_write              pipeline register write enables (PC, IF/ID, ID/EX, EX/MEM, MEM/WB)
//   if_id_flush          clear IF/ID to a NOP
//   id_ex_bubble         load NOP controls into ID/EX
//   ex_mem_bubble        load NOP controls into EX/MEM
//   state                RUN=0, MEM_WAIT=1, MD_WAIT=2
//   stall_cnt            saturating count of cycles with pc_write=0
module pipeline_stall_ctrl #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_use_hzd,
   input  logic             md_req_ex,
   input  logic             md_done,
   output logic             md_start,
   input  logic             dmem_req,
   input  logic             dmem_ready,
   input  logic             br_taken_ex,
   output logic             pc_write,
   output logic             if_id_write,
   output logic             id_ex_write,
   output logic             ex_mem_write,
   output logic             mem_wb_write,
   output logic             if_id_flush,
   output logic             id_ex_bubble,
   output logic             ex_mem_bubble,
   output logic [1:0]       state,
   output logic [CNT_W-1:0] stall_cnt
);
   typedef enum logic [1:0] {RUN = 2'd0, MEM_WAIT = 2'd1, MD_WAIT = 2'd2} state_e;
   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q;
   logic             freeze;
   always_comb begin
      pc_write      = 1'b1;
      if_id_write   = 1'b1;
      id_ex_write   = 1'b1;
      ex_mem_write  = 1'b1;
      mem_wb_write  = 1'b1;
      if_id_flush   = 1'b0;
      id_ex_bubble  = 1'b0;
      ex_mem_bubble = 1'b0;
      md_start      = 1'b0;
      freeze        = 1'b0;
      state_d       = RUN;
      if (state_q == MD_WAIT) begin
         // MEM only holds bubbles here, so memory, branch and hazard inputs are ignored
         if (!md_done) begin
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            id_ex_write   = 1'b0;
            ex_mem_bubble = 1'b1;
            state_d       = MD_WAIT;
         end
      end else begin
         // in MEM_WAIT the freeze holds until ready; on the ready cycle the RUN rules apply
         freeze = (state_q == MEM_WAIT) ? !dmem_ready : (dmem_req && !dmem_ready);
         if (freeze) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_write  = 1'b0;
            ex_mem_write = 1'b0;
            mem_wb_write = 1'b0;
            state_d      = MEM_WAIT;
         end else if (md_req_ex) begin
            // younger stages hold while older instructions drain past EX
            md_start      = 1'b1;
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            id_ex_write   = 1'b0;
            ex_mem_bubble = 1'b1;
            state_d       = MD_WAIT;
         end else if (br_taken_ex) begin
            // the flush removes any load-use dependent, so the hazard is dropped
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
         end else if (load_use_hzd) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
         end
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= RUN;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         if (!pc_write && cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
      end
   end
   assign state     = state_q;
   assign stall_cnt = cnt_q;
endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// tb_pipeline_stall_ctrl: directed vectors with hand-computed expectations for pipeline_stall_ctrl.
module tb_pipeline_stall_ctrl;
   localparam int CNT_W = 4;
   // control vector order: pc, if_id, id_ex, ex_mem, mem_wb writes, if_id_flush, id_ex_bubble, ex_mem_bubble, md_start
   localparam logic [8:0] C_NORM = 9'b11111_000_0;
   localparam logic [8:0] C_LU   = 9'b00111_010_0;
   localparam logic [8:0] C_BR   = 9'b11111_110_0;
   localparam logic [8:0] C_MDS  = 9'b00011_001_1;
   localparam logic [8:0] C_MDW  = 9'b00011_001_0;
   localparam logic [8:0] C_FRZ  = 9'b00000_000_0;
   logic clk = 1'b0;
   logic rst_n;
   logic load_use_hzd, md_req_ex, md_done, md_start, dmem_req, dmem_ready, br_taken_ex;
   logic pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write;
   logic if_id_flush, id_ex_bubble, ex_mem_bubble;
   logic [1:0] state;
   logic [CNT_W-1:0] stall_cnt;
   logic [8:0] ctrl;
   int n_checks = 0;
   int n_fail = 0;
   pipeline_stall_ctrl #(.CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .load_use_hzd(load_use_hzd), .md_req_ex(md_req_ex),
      .md_done(md_done), .md_start(md_start), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
      .br_taken_ex(br_taken_ex), .pc_write(pc_write), .if_id_write(if_id_write),
      .id_ex_write(id_ex_write), .ex_mem_write(ex_mem_write), .mem_wb_write(mem_wb_write),
      .if_id_flush(if_id_flush), .id_ex_bubble(id_ex_bubble), .ex_mem_bubble(ex_mem_bubble),
      .state(state), .stall_cnt(stall_cnt)
   );
   always #5 clk = ~clk;
   assign ctrl = {pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write,
                  if_id_flush, id_ex_bubble, ex_mem_bubble, md_start};
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   initial begin
      rst_n = 1'b0;
      {load_use_hzd, md_req_ex, md_done, dmem_req, dmem_ready, br_taken_ex} = '0;
      #2;
      check("rst_state", 32'(state), 32'd0);
      check("rst_cnt", 32'(stall_cnt), 32'd0);
      check("rst_ctrl", 32'(ctrl), 32'(C_NORM));
      step();
      step();
      rst_n = 1'b1;
      check("idle_ctrl", 32'(ctrl), 32'(C_NORM));
      // single load-use stall
      load_use_hzd = 1'b1;
      #1 check("lu_ctrl", 32'(ctrl), 32'(C_LU));
      step();
      load_use_hzd = 1'b0;
      #1 check("lu_after_ctrl", 32'(ctrl), 32'(C_NORM));
      check("lu_cnt", 32'(stall_cnt), 32'd1);
      // branch alone, then branch with load-use
      br_taken_ex = 1'b1;
      #1 check("br_ctrl", 32'(ctrl), 32'(C_BR));
      load_use_hzd = 1'b1;
      #1 check("br_lu_ctrl", 32'(ctrl), 32'(C_BR));
      step();
      {br_taken_ex, load_use_hzd} = '0;
      #1 check("br_lu_cnt", 32'(stall_cnt), 32'd1);
      check("br_state", 32'(state), 32'd0);
      // md_done in RUN is ignored
      md_done = 1'b1;
      #1 check("done_run_ctrl", 32'(ctrl), 32'(C_NORM));
      step();
      md_done = 1'b0;
      #1 check("done_run_state", 32'(state), 32'd0);
      // mul/div sequence, done 5 cycles after request
      md_req_ex = 1'b1;
      #1 check("md_start_ctrl", 32'(ctrl), 32'(C_MDS));
      step();
      for (int i = 1; i <= 4; i++) begin
         check("md_wait_state", 32'(state), 32'd2);
         check("md_wait_ctrl", 32'(ctrl), 32'(C_MDW));
         step();
      end
      md_done = 1'b1;
      dmem_req = 1'b1;
      br_taken_ex = 1'b1;
      #1 check("md_done_state", 32'(state), 32'd2);
      check("md_done_ctrl", 32'(ctrl), 32'(C_NORM));
      step();
      {md_done, md_req_ex, dmem_req, br_taken_ex} = '0;
      #1 check("md_end_state", 32'(state), 32'd0);
      check("md_cnt", 32'(stall_cnt), 32'd6);
      // memory wait with mul/div pending, done pulse coinciding with start
      dmem_req = 1'b1;
      md_req_ex = 1'b1;
      #1 check("mem_frz0", 32'(ctrl), 32'(C_FRZ));
      check("mem_state0", 32'(state), 32'd0);
      step();
      for (int i = 1; i <= 2; i++) begin
         check("mem_frz", 32'(ctrl), 32'(C_FRZ));
         check("mem_state", 32'(state), 32'd1);
         step();
      end
      dmem_ready = 1'b1;
      md_done = 1'b1;
      #1 check("mem_rdy_ctrl", 32'(ctrl), 32'(C_MDS));
      check("mem_rdy_state", 32'(state), 32'd1);
      step();
      {dmem_req, dmem_ready} = '0;
      #1 check("mem_md_state", 32'(state), 32'd2);
      check("mem_md_done_ctrl", 32'(ctrl), 32'(C_NORM));
      step();
      {md_done, md_req_ex} = '0;
      #1 check("mem_md_end_state", 32'(state), 32'd0);
      check("mem_md_cnt", 32'(stall_cnt), 32'd10);
      // saturation
      load_use_hzd = 1'b1;
      for (int i = 0; i < 20; i++) step();
      load_use_hzd = 1'b0;
      #1 check("sat_cnt", 32'(stall_cnt), 32'd15);
      // asynchronous reset while in MD_WAIT
      md_req_ex = 1'b1;
      step();
      check("pre_rst_state", 32'(state), 32'd2);
      md_req_ex = 1'b0;
      #2 rst_n = 1'b0;
      #1 check("async_rst_state", 32'(state), 32'd0);
      check("async_rst_cnt", 32'(stall_cnt), 32'd0);
      check("async_rst_ctrl", 32'(ctrl), 32'(C_NORM));
      step();
      rst_n = 1'b1;
      step();
      check("post_rst_ctrl", 32'(ctrl), 32'(C_NORM));
      check("post_rst_state", 32'(state), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/pipeline_stall_ctrl.md
Name: pipeline_stall_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage RV32 pipeline.
- Merges four event sources into one set of per-stage write-enable and bubble/flush controls:
  - load-use hazard flag from hazard detection;
  - multi-cycle mul/div busy handshake in EX;
  - data-memory wait in MEM;
  - taken branch/jump resolved in EX.
- Owns a small FSM for the multi-cycle events and a stall-cycle counter for performance monitoring.

Parameters:
CNT_W, 16, width of stall_cnt (saturating)

Ports:
clk  in  1  single system clock, rising edge
rst_n  in  1  asynchronous active-low reset
load_use_hzd  in  1  load-use hazard detected for instruction in ID
md_req_ex  in  1  EX holds a multi-cycle mul/div instruction
md_done  in  1  mul/div unit result valid (1-cycle pulse)
md_start  out  1  start pulse to mul/div unit
dmem_req  in  1  MEM stage performing load/store this cycle
dmem_ready  in  1  data memory completes access this cycle
br_taken_ex  in  1  branch/jump taken, resolved in EX
pc_write  out  1  PC register update enable
if_id_write  out  1  IF/ID register write enable
id_ex_write  out  1  ID/EX register write enable
ex_mem_write  out  1  EX/MEM register write enable
mem_wb_write  out  1  MEM/WB register write enable
if_id_flush  out  1  clear IF/ID to NOP
id_ex_bubble  out  1  load NOP controls into ID/EX
ex_mem_bubble  out  1  load NOP controls into EX/MEM
state  out  2  FSM state: RUN=0, MEM_WAIT=1, MD_WAIT=2
stall_cnt  out  CNT_W  count of cycles with pc_write=0

Behaviour:
- Reset (rst_n=0, async):
  - state=RUN, stall_cnt=0, md_start=0.
  - Outputs are combinational from state plus inputs. With inputs 0 in RUN: all *_write=1, all flush/bubble=0.
- Default, all states: every *_write=1, every flush/bubble=0, md_start=0, unless overridden by the rules below.
- Priority order, evaluated in RUN and on exit from MEM_WAIT: MEM stall > MD start > branch flush > load-use.
- MEM stall: dmem_req=1 and dmem_ready=0.
  - All five *_write=0; no bubbles.
  - Next state MEM_WAIT.
- MEM_WAIT:
  - While dmem_ready=0: full freeze as above.
  - Cycle with dmem_ready=1: freeze released and RUN rules apply in the same cycle (MD start, branch, load-use may fire).
  - Next state is RUN, or MD_WAIT if MD start fired.
- MD start (md_req_ex=1, no MEM stall):
  - md_start=1 for exactly one cycle.
  - pc_write, if_id_write, id_ex_write=0.
  - ex_mem_bubble=1; mem_wb_write=1, so older instructions drain.
  - Next state MD_WAIT.
- MD_WAIT:
  - pc_write, if_id_write, id_ex_write=0; ex_mem_bubble=1; md_start=0.
  - dmem_req, br_taken_ex, load_use_hzd ignored (MEM holds only bubbles).
  - md_done=1: that cycle all writes=1, ex_mem_bubble=0 (result captured); next state RUN.
  - md_done in RUN or MEM_WAIT: ignored.
  - md_done in the same cycle as md_start: ignored. Minimum wait is 1 cycle in MD_WAIT.
- Branch flush (RUN, no higher event):
  - if_id_flush=1, id_ex_bubble=1, pc_write=1 (target loaded). Single cycle, no state change.
  - load_use_hzd in the same cycle is ignored (dependent instruction is flushed).
- Load-use (RUN, no higher event):
  - pc_write=0, if_id_write=0, id_ex_bubble=1; others write.
  - One stall per asserted cycle; no state change.
- stall_cnt:
  - Increments by 1 on each rising edge where pc_write=0.
  - Saturates at 2^CNT_W-1 (no wrap).
  - Cleared only by reset.
- Reset mid-MD_WAIT or mid-MEM_WAIT: immediate return to RUN. md_start is not re-issued until md_req_ex is seen in RUN.

Test Plan:
- Reset: hold rst_n=0, inputs 0 -> state=0, stall_cnt=0, all writes=1, flush/bubble/md_start=0. Assert rst_n low asynchronously mid-cycle -> outputs change immediately.
- Load-use: load_use_hzd=1 for 1 cycle -> pc_write=0, if_id_write=0, id_ex_bubble=1 that cycle only; stall_cnt=1.
- Load-use + branch same cycle: br_taken_ex=1, load_use_hzd=1 -> if_id_flush=1, id_ex_bubble=1, pc_write=1; stall_cnt unchanged.
- MD sequence: md_req_ex=1 in RUN, md_done pulse 5 cycles later ->
  - md_start high 1 cycle;
  - state=2 for 5 cycles, ex_mem_bubble=1 throughout;
  - done cycle all writes=1, state back to 0;
  - stall_cnt=5.
- MEM wait then MD: dmem_req=1, dmem_ready=0 for 3 cycles with md_req_ex=1 ->
  - all writes=0 for 3 cycles, state=1, md_start=0;
  - ready cycle: md_start=1, state->2.
- Saturation / reset mid-op: CNT_W=4, hold load_use_hzd=1 for 20 cycles -> stall_cnt stops at 15. Assert rst_n=0 during MD_WAIT -> state=0, stall_cnt=0, md_start=0.
